fir_tap_sequencer: RTL and testbench
====================================

// Module: fir_tap_sequencer
// PURPOSE
//   Time-multiplexed FIR controller: one saturating multiply-accumulate unit is shared
//   across all NTAPS taps, one tap per clock.
//   Holds the sample window and a run-time writable coefficient bank.
//   Accepts one sample per valid/ready handshake and returns the saturated filter sum.
//   Sits between the sample source and the downstream consumer.
//   Area-reduced alternative to the fully parallel multiply/add-tree filter.
// PARAMETERS
//   NTAPS  4                 number of taps (>=2)
//   DW     16                signed sample/coefficient/result width
//   AW     clog2(NTAPS)      coefficient address width
// PORTS
//   system1000      in   1    clock, rising edge
//   system1000_rst  in   1    asynchronous reset, active high
//   in_data         in   DW   signed input sample
//   in_valid        in   1    in_data valid
//   in_ready        out  1    block can accept a sample
//   out_data        out  DW   signed filter result
//   out_valid       out  1    out_data valid
//   out_ready       in   1    consumer accepts out_data
//   out_sat         out  1    saturation occurred while computing out_data
//   cfg_we          in   1    coefficient write strobe
//   cfg_addr        in   AW   coefficient index (0 multiplies newest sample)
//   cfg_data        in   DW   signed coefficient value
//   cfg_ready       out  1    coefficient write will be taken this cycle
//   busy            out  1    state != IDLE
// BEHAVIOUR
//   Reset (async assert, sync deassert by clock):
//   - state=IDLE, window all 0, acc=0, cnt=0.
//   - Outputs: out_data=0, out_valid=0, out_sat=0, busy=0.
//   - Coefficients load defaults: coef[0..3] = 2, 3, -2, 8. For NTAPS>4, the rest = 0.
//   - A reset mid-operation discards the in-flight sample. No output is produced for it.
//   States:
//   - IDLE: in_ready=1, cfg_ready=1.
//     - Edge with in_valid&in_ready: win[k]<=win[k-1], win[0]<=in_data, acc<=0,
//       satf<=0, cnt<=0, go to MAC.
//     - Edge with cfg_we&cfg_ready: coef[cfg_addr]<=cfg_data.
//     - If both fire on the same edge, both are taken. The sample uses the new
//       coefficient, because MAC starts on the next cycle.
//   - MAC: in_ready=0, cfg_ready=0. cfg_we is ignored, with no error.
//     - Each edge: acc <= satPlus(acc, satMult(coef[cnt], win[cnt])); satf |= any clip; cnt++.
//     - On the edge with cnt==NTAPS-1: go to HOLD, out_data<=next acc, out_sat<=next satf,
//       out_valid<=1.
//   - HOLD: in_ready=0, cfg_ready=0. out_valid=1; out_data and out_sat stable.
//     - Edge with out_ready: out_valid<=0, go to IDLE.
//   Latency: out_valid rises exactly NTAPS cycles after the input handshake edge.
//   Throughput: at best one sample per NTAPS+2 cycles (NTAPS MAC + 1 HOLD + 1 IDLE).
//   Arithmetic:
//   - satMult: full 2*DW signed product, clipped to [-2^(DW-1), 2^(DW-1)-1]. No shift.
//   - satPlus: DW+1 signed sum, clipped to the same range.
//   - Taps accumulate in order 0..NTAPS-1, with saturation applied at every step.
//   - out_sat is set if any step clipped.
//   - cfg_addr >= NTAPS: the write is ignored.
// STRUCTURE
//   Shared package fir_pkg:
//   - DW, SAT_MAX/SAT_MIN constants.
//   - Default coefficient vector.
//   - State encoding IDLE/MAC/HOLD.
//   - satMult/satPlus helper functions.
//   Sub-module fir_sat_mac:
//   - Combinational: acc, a, b -> sum, clip.
//   - The single shared arithmetic unit.
//   Top level: FSM, tap counter, window shift register, coefficient bank, output register.
// TESTING
//   1 Reset, then sample 1 -> out_data=2, out_sat=0, out_valid exactly 4 cycles after accept.
//   2 Continue with sample 10 -> window [10,1,0,0] -> out_data=23.
//     Then sample -5 -> window [-5,10,1,0] -> out_data=18.
//   3 Reset, write coef[0]=32767, then sample 2 -> out_data=32767, out_sat=1.
//     Then sample -32768 -> window [-32768,2,0,0], MAC step 0 clips -> out_data=-32762, out_sat=1.
//   4 Hold out_ready=0 for 5 cycles in HOLD -> out_valid stays 1, data stable, in_ready=0.
//     A later out_ready pulse returns the block to IDLE one cycle later.
//   5 Pulse cfg_we (addr 1, data 100) during MAC -> cfg_ready=0, the write is ignored,
//     and the next result still uses coef[1]=3.
//   6 Assert system1000_rst during MAC cycle 2 -> outputs 0 immediately, busy=0.
//     The next sample 1 yields out_data=2 (default coefficients, zero window).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants, state encoding and saturating arithmetic for the
// time-multiplexed FIR tap sequencer.
package fir_pkg;

    localparam int DW = 16;

    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    typedef struct packed {
        logic [DW-1:0] val;
        logic          clip;
    } sat_t;

    // Power-on coefficient bank; taps beyond the fourth start at zero.
    function automatic logic [DW-1:0] def_coef(input int idx);
        case (idx)
            0:       def_coef = DW'(2);
            1:       def_coef = DW'(3);
            2:       def_coef = DW'(-2);
            3:       def_coef = DW'(8);
            default: def_coef = '0;
        endcase
    endfunction

    function automatic sat_t sat_mult(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] p;
        sat_t r;
        p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
        // In range only when the upper DW+1 bits are a pure sign extension.
        if ((&p[2*DW-1:DW-1]) || !(|p[2*DW-1:DW-1])) begin
            r.val  = p[DW-1:0];
            r.clip = 1'b0;
        end else begin
            r.val  = p[2*DW-1] ? SAT_MIN : SAT_MAX;
            r.clip = 1'b1;
        end
        return r;
    endfunction

    function automatic sat_t sat_plus(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        sat_t r;
        s = {a[DW-1], a} + {b[DW-1], b};
        if (s[DW] != s[DW-1]) begin
            r.val  = s[DW] ? SAT_MIN : SAT_MAX;
            r.clip = 1'b1;
        end else begin
            r.val  = s[DW-1:0];
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_sat_mac.sv
// The single shared saturating multiply-accumulate step: sum = sat(acc + sat(a*b)).
module fir_sat_mac
    import fir_pkg::*;
(
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum,
    output logic          clip
);

    sat_t prod;
    sat_t total;

    always_comb begin
        prod  = sat_mult(a, b);
        total = sat_plus(acc, prod.val);
        sum   = total.val;
        clip  = prod.clip | total.clip;
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR controller that walks one shared saturating MAC across all taps,
// one tap per clock, with a run-time writable coefficient bank.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS = 4,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic          system1000,
    input  logic          system1000_rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sat,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    output logic          cfg_ready,
    output logic          busy,
    output logic [1:0]    fsm_state
);

    // Handshakes: a sample moves on an edge where in_valid && in_ready; a
    // result leaves on an edge where out_valid && out_ready; a coefficient
    // write lands on an edge where cfg_we && cfg_ready.

    logic [1:0]    state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] acc;
    logic          satf;
    logic [DW-1:0] win  [NTAPS];
    logic [DW-1:0] coef [NTAPS];
    logic [DW-1:0] mac_sum;
    logic          mac_clip;

    fir_sat_mac u_mac (
        .acc  (acc),
        .a    (coef[cnt]),
        .b    (win[cnt]),
        .sum  (mac_sum),
        .clip (mac_clip)
    );

    assign in_ready  = (state == IDLE);
    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            satf      <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                win[i]  <= '0;
                coef[i] <= def_coef(i);
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = NTAPS - 1; k > 0; k--) begin
                            win[k] <= win[k-1];
                        end
                        win[0] <= in_data;
                        acc    <= '0;
                        satf   <= 1'b0;
                        cnt    <= '0;
                        state  <= MAC;
                    end
                    // A same-edge write is seen by the sample, since MAC starts next cycle.
                    if (cfg_we && (32'(cfg_addr) < NTAPS)) begin
                        coef[cfg_addr] <= cfg_data;
                    end
                end
                MAC: begin
                    acc  <= mac_sum;
                    satf <= satf | mac_clip;
                    cnt  <= cnt + AW'(1);
                    if (cnt == AW'(NTAPS - 1)) begin
                        out_data  <= mac_sum;
                        out_sat   <= satf | mac_clip;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: hand-computed results for default and
// rewritten coefficients, saturation, HOLD back-pressure, MAC-time writes and reset.
module tb_fir_tap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sat;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_ready;
    logic        busy;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_tap_sequencer dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sat        (out_sat),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_ready      (cfg_ready),
        .busy           (busy),
        .fsm_state      (fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coef(input logic [1:0] addr, input logic [15:0] data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    // Sends one sample, optionally pokes a coefficient write during MAC and
    // stalls in HOLD, then checks the result and releases it.
    task automatic run_sample(input string tag, input logic [15:0] d, input logic [15:0] exp_d,
                              input logic exp_s, input int hold_cycles, input bit mac_cfg);
        int lat;
        logic [15:0] held;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        if (mac_cfg) begin
            chk({tag, "_cfg_ready_mac"}, 32'(cfg_ready), 32'd0);
            cfg_we   = 1'b1;
            cfg_addr = 2'd1;
            cfg_data = 16'd100;
            @(posedge clk);
            #1 cfg_we = 1'b0;
            lat = 1;
        end
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
        chk({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        held = out_data;
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(out_data), 32'(held));
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rel_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // window [1,0,0,0] -> 2*1
        run_sample("t1", 16'd1, 16'd2, 1'b0, 0, 1'b0);
        // window [10,1,0,0] -> 20+3
        run_sample("t2a", 16'd10, 16'd23, 1'b0, 0, 1'b0);
        // window [-5,10,1,0] -> -10+30-2, held 5 cycles in HOLD
        run_sample("t2b", 16'hFFFB, 16'd18, 1'b0, 5, 1'b0);
        // window [0,-5,10,1] -> 0-15-20+8 = -27; MAC-time write to coef[1] ignored
        run_sample("t5", 16'd0, 16'hFFE5, 1'b0, 0, 1'b1);

        do_reset();
        write_coef(2'd0, 16'h7FFF);
        // 32767*2 clips to 32767
        run_sample("t3a", 16'd2, 16'h7FFF, 1'b1, 0, 1'b0);
        // window [-32768,2,0,0]: step 0 clips to -32768, then +6
        run_sample("t3b", 16'h8000, 16'h8006, 1'b1, 0, 1'b0);

        // reset during MAC cycle 2 drops the sample
        @(negedge clk);
        in_data  = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_out_data", 32'(out_data), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_sat", 32'(out_sat), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_sample("t6", 16'd1, 16'd2, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
